// File: rtl/button_event_pkg.sv
// button_event_pkg: event and FSM state types shared by the button event queue, plus event_code packing
package button_event_pkg;
  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_REPEAT  = 2'd1,
    EV_RELEASE = 2'd2
  } event_type_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } btn_state_t;
  function automatic logic [3:0] pack_event(input event_type_t t, input logic [1:0] idx);
    return {t, idx};
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO, power-of-two depth, simultaneous push/pop allowed when full
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write request and data (ignored when full unless popping the same cycle)
//   pop/rdata  : read request (ignored when empty) and head entry (0 when empty)
//   full/empty/count : occupancy status
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d  = do_push ? wr_q + PW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: turns debounced button levels into press/repeat/release events queued for software
//   clk, reset      : clock, synchronous active-high reset
//   buttons_db      : debounced levels, 1 = pressed
//   levels          : buttons_db delayed one cycle
//   event_valid/event_code/event_ready : FIFO head {type, index} with valid/ready pop
//   fifo_count      : entries held
//   overflow/clear_overflow : sticky lost-event flag and its clear
module button_event_queue
  import button_event_pkg::*;
#(
  parameter int N_BUTTONS  = 4,
  parameter int CLK_HZ     = 50000000,
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_BUTTONS-1:0]          buttons_db,
  output logic [N_BUTTONS-1:0]          levels,
  output logic                          event_valid,
  output logic [3:0]                    event_code,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);
  localparam int TICK = CLK_HZ / 1000;
  localparam int DW   = TICK > 1 ? $clog2(TICK) : 1;
  localparam int CW   = $clog2(HOLD_MS + REPEAT_MS + 1);
  logic [N_BUTTONS-1:0] buttons_q, buttons_d, armed_q, armed_d, rise, fall;
  logic [N_BUTTONS-1:0] gen, slot_v_q, slot_v_d, grant;
  event_type_t gen_t [N_BUTTONS];
  event_type_t slot_t_q [N_BUTTONS];
  event_type_t slot_t_d [N_BUTTONS];
  event_type_t push_t;
  logic [1:0] push_idx;
  logic [DW-1:0] div_q, div_d;
  logic ms_tick, overflow_q, overflow_d, overwrite, push, fifo_full, fifo_empty;
  assign levels      = buttons_q;
  assign overflow    = overflow_q;
  assign event_valid = !fifo_empty;
  // A button held through reset must be seen released before it can produce a new press
  assign rise    = buttons_db & ~buttons_q & armed_q;
  assign fall    = ~buttons_db & buttons_q;
  assign ms_tick = div_q == DW'(TICK - 1);
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic ev;
    event_type_t ev_t;
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev      = 1'b0;
      ev_t    = EV_PRESS;
      cnt_inc = cnt_q + CW'(1);
      if (state_q == S_IDLE) begin
        if (rise[g]) begin
          ev      = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end else if (fall[g]) begin
        ev      = 1'b1;
        ev_t    = EV_RELEASE;
        state_d = S_IDLE;
      end else if (ms_tick) begin
        if (cnt_inc == (state_q == S_HOLD ? CW'(HOLD_MS) : CW'(REPEAT_MS))) begin
          ev      = 1'b1;
          ev_t    = EV_REPEAT;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
    assign gen[g]   = ev;
    assign gen_t[g] = ev_t;
  end
  // Fixed priority: lowest-index pending slot goes to the FIFO
  always_comb begin
    grant    = '0;
    push_t   = EV_PRESS;
    push_idx = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (slot_v_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        push_t   = slot_t_q[i];
        push_idx = 2'(i);
      end
    end
    push = |slot_v_q && (!fifo_full || (event_ready && !fifo_empty));
  end
  // A new event always lands in its slot; it only counts as lost data if the old one was not pushed
  always_comb begin
    slot_v_d  = slot_v_q;
    slot_t_d  = slot_t_q;
    overwrite = 1'b0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (grant[i] && push) slot_v_d[i] = 1'b0;
      if (gen[i]) begin
        slot_v_d[i] = 1'b1;
        slot_t_d[i] = gen_t[i];
        overwrite   = overwrite | (slot_v_q[i] && !(grant[i] && push));
      end
    end
    overflow_d = overwrite | (overflow_q & ~clear_overflow);
    buttons_d  = buttons_db;
    armed_d    = armed_q | ~buttons_db;
    div_d      = ms_tick ? '0 : div_q + DW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons_q  <= '0;
      armed_q    <= '0;
      div_q      <= '0;
      slot_v_q   <= '0;
      slot_t_q   <= '{default: EV_PRESS};
      overflow_q <= 1'b0;
    end else begin
      buttons_q  <= buttons_d;
      armed_q    <= armed_d;
      div_q      <= div_d;
      slot_v_q   <= slot_v_d;
      slot_t_q   <= slot_t_d;
      overflow_q <= overflow_d;
    end
  end
  event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (pack_event(push_t, push_idx)),
    .pop   (event_ready),
    .rdata (event_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: scoreboard bench; stimulus queues expected codes, a negedge monitor checks pops
module tb_button_event_queue;
  logic clk = 1'b0;
  logic reset, event_ready, clear_overflow, event_valid, overflow;
  logic [3:0] buttons_db, levels, event_code, mon_exp;
  logic [2:0] fifo_count;
  logic [3:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  button_event_queue #(
    .N_BUTTONS(4), .CLK_HZ(4000), .HOLD_MS(3), .REPEAT_MS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .buttons_db(buttons_db), .levels(levels),
    .event_valid(event_valid), .event_code(event_code), .event_ready(event_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );
  always @(negedge clk) begin
    if (!reset && event_valid && event_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got %h, expected no event", event_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (event_code !== mon_exp) begin
          errors++;
          $display("FAIL event: got %h, expected %h", event_code, mon_exp);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_count"}, fifo_count, 0);
  endtask
  initial begin
    reset = 1'b1;
    buttons_db = '0;
    event_ready = 1'b0;
    clear_overflow = 1'b0;
    step();
    step();
    chk("rst_levels", levels, 0);
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (3) step();
    // short press of button 1: press then release, no repeat
    event_ready = 1'b1;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h9);
    buttons_db = 4'b0010;
    step();
    chk("levels_b1", levels, 4'b0010);
    repeat (7) step();
    buttons_db = '0;
    wait_drain("short");
    // 8 ms hold of button 0: repeats at tick 3, 5, 7
    exp_q.push_back(4'h0);
    repeat (3) exp_q.push_back(4'h4);
    exp_q.push_back(4'h8);
    buttons_db = 4'b0001;
    repeat (32) step();
    buttons_db = '0;
    wait_drain("hold");
    // buttons 0 and 2 together: pushed on consecutive cycles, index 0 first
    event_ready = 1'b0;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'hA);
    buttons_db = 4'b0101;
    step();
    step();
    chk("dual_count1", fifo_count, 1);
    chk("dual_head", event_code, 4'h0);
    step();
    chk("dual_count2", fifo_count, 2);
    buttons_db = '0;
    repeat (3) step();
    event_ready = 1'b1;
    wait_drain("dual");
    // fill the FIFO, then stall and overwrite button 3's slot
    event_ready = 1'b0;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'h9);
    buttons_db = 4'b0011;
    repeat (4) step();
    buttons_db = '0;
    repeat (4) step();
    chk("full_count", fifo_count, 4);
    buttons_db = 4'b1000;
    repeat (4) step();
    chk("wait_ovf", overflow, 0);
    chk("wait_count", fifo_count, 4);
    buttons_db = '0;
    repeat (3) step();
    chk("ovf_set", overflow, 1);
    chk("levels_zero", levels, 0);
    exp_q.push_back(4'hB);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    // single pop while full: pending release of button 3 pushed the same cycle
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
    chk("popfull_count", fifo_count, 4);
    chk("popfull_head", event_code, 4'h1);
    step();
    chk("popfull_hold", fifo_count, 4);
    event_ready = 1'b1;
    wait_drain("popfull");
    // reset while button 0 is in REPEAT; it must be released before a new press
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h4);
    buttons_db = 4'b0001;
    repeat (16) step();
    chk("pre_reset_drained", exp_q.size(), 0);
    reset = 1'b1;
    step();
    chk("mid_rst_levels", levels, 0);
    chk("mid_rst_valid", event_valid, 0);
    chk("mid_rst_code", event_code, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (10) step();
    chk("held_no_press", event_valid, 0);
    chk("held_count", fifo_count, 0);
    chk("held_levels", levels, 4'b0001);
    buttons_db = '0;
    repeat (3) step();
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h8);
    buttons_db = 4'b0001;
    repeat (4) step();
    buttons_db = '0;
    wait_drain("repress");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
